mixcol_seq: RTL and testbench

Column-serial AES MixColumns engine with valid/ready handshakes on input and output. It shares one parameterizable column-mixing datapath across the four 32-bit columns of a 128-bit state, processing NCOL columns per cycle. It sits between the SubBytes/ShiftRows stage and AddRoundKey in the round pipeline. A per-block skip flag passes the state through unchanged for the final AES round.

---
 rtl/mixcol_seq.sv | 116 +++++++++++
 tb/tb_mixcol_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mixcol_seq.sv
`default_nettype none
// ============================================================================
// Module      : mixcol_seq
// Description : Column-serial AES MixColumns engine with valid/ready
//               handshakes, mixing NCOL columns per cycle, with a pass-through
//               skip for the final round.
// Revision    : 1.0 - initial release
// ============================================================================
module mixcol_seq #(
    parameter int NCOL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_skip,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BUSY  = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;
    localparam logic [1:0] c_STEP  = 2'(NCOL);
    localparam logic [2:0] c_STEP3 = 3'(NCOL);

    generate
        if (NCOL != 1 && NCOL != 2 && NCOL != 4) begin : g_bad_ncol
            $error("mixcol_seq: NCOL must be 1, 2 or 4");
        end
    endgenerate

    logic [1:0]   r_state;
    logic [1:0]   r_cnt;
    logic [127:0] r_st;
    logic [127:0] w_mixed_st;
    logic         w_last;

    logic [1:0]   w_lane_idx [NCOL];
    logic [31:0]  w_lane_in  [NCOL];
    logic [31:0]  w_lane_out [NCOL];

    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
    endfunction

    // bj = aj ^ t ^ xt(aj ^ a(j+1)), which equals 2*aj ^ 3*a(j+1) ^ a(j+2) ^ a(j+3)
    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0]  t;
        logic [31:0] b;
        t = a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24];
        for (int j = 0; j < 4; j++) begin
            b[8*j +: 8] = a[8*j +: 8] ^ t ^ xt(a[8*j +: 8] ^ a[8*((j+1)%4) +: 8]);
        end
        return b;
    endfunction

    // Each lane mixes one column of the current group; groups are NCOL-aligned
    generate
        for (genvar g = 0; g < NCOL; g++) begin : g_lane
            assign w_lane_idx[g] = r_cnt + 2'(g);
            assign w_lane_in[g]  = r_st[{w_lane_idx[g], 5'd0} +: 32];
            assign w_lane_out[g] = mix_col(w_lane_in[g]);
        end
    endgenerate

    always_comb begin
        w_mixed_st = r_st;
        for (int g = 0; g < NCOL; g++) begin
            w_mixed_st[{w_lane_idx[g], 5'd0} +: 32] = w_lane_out[g];
        end
    end

    assign w_last = (({1'b0, r_cnt} + c_STEP3) == 3'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_cnt   <= 2'd0;
            r_st    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_st    <= in_data;
                        r_cnt   <= 2'd0;
                        r_state <= in_skip ? c_DONE : c_BUSY;
                    end
                end
                c_BUSY: begin
                    r_st  <= w_mixed_st;
                    r_cnt <= r_cnt + c_STEP;
                    if (w_last) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign busy      = (r_state == c_BUSY);
    assign out_data  = r_st;

endmodule
`default_nettype wire

// File: tb/tb_mixcol_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mixcol_seq
// Description : Self-checking bench for mixcol_seq with NCOL = 1, 2 and 4
//               side by side against a GF(2^8) reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mixcol_seq;

    localparam int NDUT = 3;
    localparam logic [127:0] KV     = 128'h4c31262d_d5d4d4d4_5c220af2_455313db;
    localparam logic [127:0] KV_OUT = 128'hf8bd7e4d_d6d7d5d5_9d58dc9f_bca14d8e;
    localparam logic [127:0] FP     = 128'hc6c6c6c6_01010101_c6c6c6c6_01010101;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid  [NDUT];
    logic         in_ready  [NDUT];
    logic [127:0] in_data   [NDUT];
    logic         in_skip   [NDUT];
    logic         out_valid [NDUT];
    logic         out_ready [NDUT];
    logic [127:0] out_data  [NDUT];
    logic         busy      [NDUT];

    generate
        for (genvar k = 0; k < NDUT; k++) begin : g_dut
            mixcol_seq #(.NCOL(1 << k)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid[k]),
                .in_ready  (in_ready[k]),
                .in_data   (in_data[k]),
                .in_skip   (in_skip[k]),
                .out_valid (out_valid[k]),
                .out_ready (out_ready[k]),
                .out_data  (out_data[k]),
                .busy      (busy[k])
            );
        end
    endgenerate

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int acc_cnt [NDUT] = '{default: 0};

    typedef struct {
        logic [127:0] d;
        int           due;
    } item_t;
    item_t sb [NDUT][$];

    task automatic chk(input string name, input int k, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d (NCOL=%0d) t=%0t: got %h, expected %h", name, k, 1 << k, $time, act, exp);
        end
    endtask

    // Reference: GF(2^8) products with the MixColumns circulant matrix
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [1:0] m);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 2; i++) begin
            if (m[i]) r = r ^ p;
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic skip);
        logic [7:0]   a [4];
        logic [127:0] res;
        res = d;
        if (!skip) begin
            for (int c = 0; c < 4; c++) begin
                for (int j = 0; j < 4; j++) a[j] = d[32*c + 8*j +: 8];
                for (int j = 0; j < 4; j++) begin
                    res[32*c + 8*j +: 8] = gmul(a[j], 2'd2) ^ gmul(a[(j+1)%4], 2'd3)
                                         ^ a[(j+2)%4] ^ a[(j+3)%4];
                end
            end
        end
        return res;
    endfunction

    // Scoreboard bookkeeping at the active edge
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            for (int k = 0; k < NDUT; k++) begin
                if (out_valid[k] && out_ready[k] && sb[k].size() > 0) void'(sb[k].pop_front());
                if (in_valid[k] && in_ready[k]) begin
                    sb[k].push_back('{model(in_data[k], in_skip[k]),
                                      cyc + 1 + (in_skip[k] ? 0 : (4 >> k))});
                    acc_cnt[k] <= acc_cnt[k] + 1;
                end
            end
        end
    end

    always @(negedge rst_n) begin
        for (int k = 0; k < NDUT; k++) sb[k].delete();
    end

    // Compare process: every DUT output checked on every falling edge
    always @(negedge clk) begin
        logic ev;
        logic [127:0] ed;
        for (int k = 0; k < NDUT; k++) begin
            if (!rst_n) begin
                chk("rst_in_ready",  k, 128'(in_ready[k]),  128'd1);
                chk("rst_out_valid", k, 128'(out_valid[k]), 128'd0);
                chk("rst_busy",      k, 128'(busy[k]),      128'd0);
                chk("rst_out_data",  k, out_data[k],        128'd0);
            end else begin
                ev = (sb[k].size() > 0) ? (cyc >= sb[k][0].due) : 1'b0;
                ed = (sb[k].size() > 0) ? sb[k][0].d : '0;
                chk("sb_out_valid", k, 128'(out_valid[k]), 128'(ev));
                if (ev) chk("sb_out_data", k, out_data[k], ed);
                chk("sb_in_ready", k, 128'(in_ready[k]), 128'(sb[k].size() == 0));
                chk("sb_busy",     k, 128'(busy[k]),     128'((sb[k].size() > 0) && !ev));
            end
        end
    end

    task automatic send(input int k, input logic [127:0] d, input logic s, output int acc);
        int n;
        @(negedge clk);
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        in_skip[k]  = s;
        n = 0;
        while (!in_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", k, 128'(in_ready[k]), 128'd1);
        acc = cyc + 1;
        @(negedge clk);
        in_valid[k] = 1'b0;
        in_data[k]  = ~d;
        in_skip[k]  = ~s;
    endtask

    task automatic recv(input int k, input int acc, input logic [127:0] exp, input int lat, input int stall);
        int n;
        n = 0;
        while (!out_valid[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid[k]) begin
            vectors++;
            miscompares++;
            $display("FAIL recv_timeout dut%0d: got no out_valid, expected one within 40 cycles", k);
            return;
        end
        chk("latency",  k, 128'(cyc - acc), 128'(lat));
        chk("out_data", k, out_data[k], exp);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_out_valid", k, 128'(out_valid[k]), 128'd1);
            chk("stall_out_data",  k, out_data[k], exp);
            chk("stall_in_ready",  k, 128'(in_ready[k]), 128'd0);
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
        chk("post_in_ready",  k, 128'(in_ready[k]),  128'd1);
        chk("post_out_valid", k, 128'(out_valid[k]), 128'd0);
    endtask

    task automatic rand_run(input int k, input int nblk);
        int n;
        int base;
        n = 0;
        base = acc_cnt[k];
        while (acc_cnt[k] - base < nblk && n < 20000) begin
            @(negedge clk);
            in_valid[k]  = ($urandom_range(0, 3) != 0);
            in_data[k]   = {$urandom, $urandom, $urandom, $urandom};
            in_skip[k]   = ($urandom_range(0, 3) == 0);
            out_ready[k] = ($urandom_range(0, 2) != 0);
            n++;
        end
        chk("random_progress", k, 128'(acc_cnt[k] - base >= nblk), 128'd1);
        @(negedge clk);
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
    endtask

    initial begin
        int acc;
        for (int k = 0; k < NDUT; k++) begin
            in_valid[k]  = 1'b0;
            in_skip[k]   = 1'b0;
            out_ready[k] = 1'b0;
            in_data[k]   = '0;
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) chk("init_in_ready", k, 128'(in_ready[k]), 128'd1);

        // Pin the model against hand-known values
        chk("model_known", 0, model(KV, 1'b0), KV_OUT);
        chk("model_fixed", 0, model(FP, 1'b0), FP);
        chk("model_skip",  0, model(KV, 1'b1), KV);

        for (int k = 0; k < NDUT; k++) begin
            send(k, KV, 1'b0, acc);
            recv(k, acc, KV_OUT, 4 >> k, 0);
            send(k, FP, 1'b0, acc);
            recv(k, acc, FP, 4 >> k, 0);
            send(k, KV, 1'b1, acc);
            recv(k, acc, KV, 0, 0);
        end

        // Backpressure with a competing request held during the stall
        send(0, KV, 1'b0, acc);
        in_valid[0] = 1'b1;
        in_data[0]  = FP;
        recv(0, acc, KV_OUT, 4, 10);
        @(negedge clk);
        chk("bp_single_xfer", 0, 128'(out_valid[0]), 128'd0);

        // Asynchronous reset while mid-BUSY
        send(0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, acc);
        @(negedge clk);
        chk("busy_before_rst", 0, 128'(busy[0]), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("async_in_ready",  k, 128'(in_ready[k]),  128'd1);
            chk("async_out_valid", k, 128'(out_valid[k]), 128'd0);
            chk("async_busy",      k, 128'(busy[k]),      128'd0);
            chk("async_out_data",  k, out_data[k],        128'd0);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_out_after_rst", 0, 128'(out_valid[0]), 128'd0);
        end
        send(0, KV, 1'b0, acc);
        recv(0, acc, KV_OUT, 4, 0);

        // Random traffic on all three engines in parallel
        for (int k = 0; k < NDUT; k++) begin
            fork
                automatic int kk = k;
                rand_run(kk, 334);
            join_none
        end
        wait fork;
        repeat (20) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk("drain_empty",   k, 128'(sb[k].size()), 128'd0);
            chk("drain_ready",   k, 128'(in_ready[k]),  128'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
